// File: rtl/cam_default_reg_writer_pkg.sv
// Shared constants, power-up register table and state encoding for the
// camera default-register writer.
package cam_cfg_pkg;

  // SCCB write address of the sensor.
  localparam logic [7:0] CAM_DEVICE_ADDR = 8'h42;

  // Number of entries in the power-up table.
  localparam int unsigned CAM_NUM_REGS = 8;

  // Width needed to select one table entry.
  localparam int unsigned TABLE_SEL_W = $clog2(CAM_NUM_REGS);

  // Power-up table, {reg_addr, value}. Entry 0 is the sensor soft reset,
  // which needs a settling delay before the next write.
  localparam logic [15:0] REG_TABLE [0:CAM_NUM_REGS-1] = '{
    16'h1280,  // COM7: soft reset
    16'h1204,  // COM7: RGB output
    16'h1101,  // CLKRC
    16'h0C00,  // COM3
    16'h3E00,  // COM14
    16'h40D0,  // COM15: RGB565
    16'h8C00,  // RGB444 off
    16'h3A04   // TSLB
  };

  // Bus framing: three phases (device, register, value) of nine bit-slots,
  // the ninth slot being the released don't-care/ACK bit.
  localparam int unsigned NUM_PHASES     = 3;
  localparam int unsigned BITS_PER_PHASE = 9;

  // Counter widths.
  localparam int unsigned PHASE_CNT_W = 2;
  localparam int unsigned BIT_CNT_W   = 4;
  localparam int unsigned QTR_CNT_W   = 2;
  localparam int unsigned TICK_CNT_W  = 16;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DELAY = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Table lookup that returns zero for indices past the end of the table.
  function automatic logic [15:0] table_entry(input int unsigned idx);
    logic [15:0] entry;
    entry = 16'h0000;
    for (int unsigned k = 0; k < CAM_NUM_REGS; k++) begin
      entry = (idx == k) ? REG_TABLE[k[TABLE_SEL_W-1:0]] : entry;
    end
    return entry;
  endfunction

endpackage

// File: rtl/cam_default_reg_writer.sv
// Power-up configurator: walks the register table and writes each pair to the
// camera sensor with a 3-phase SCCB write. All state advances on i_enable
// ticks only; the bus pins are driven straight from flops.
module cam_default_reg_writer
  import cam_cfg_pkg::*;
#(
  parameter logic [7:0]  DEVICE_ADDR = CAM_DEVICE_ADDR,
  parameter int unsigned NUM_REGS    = CAM_NUM_REGS,
  parameter int unsigned DELAY_TICKS = 1000,
  parameter int unsigned GAP_TICKS   = 8
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_sioc,
  output logic o_siod,
  output logic o_siod_oe,
  output logic o_busy,
  output logic o_done
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS + 1);

  localparam logic [IDX_W-1:0]       IDX_ZERO   = IDX_W'(0);
  localparam logic [IDX_W-1:0]       IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0]       IDX_END    = IDX_W'(NUM_REGS);
  localparam logic [PHASE_CNT_W-1:0] PHASE_ZERO = PHASE_CNT_W'(0);
  localparam logic [PHASE_CNT_W-1:0] PHASE_ONE  = PHASE_CNT_W'(1);
  localparam logic [PHASE_CNT_W-1:0] PHASE_LAST = PHASE_CNT_W'(NUM_PHASES - 1);
  localparam logic [BIT_CNT_W-1:0]   BIT_ZERO   = BIT_CNT_W'(0);
  localparam logic [BIT_CNT_W-1:0]   BIT_ONE    = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0]   ACK_BIT    = BIT_CNT_W'(BITS_PER_PHASE - 1);
  localparam logic [QTR_CNT_W-1:0]   QTR_0      = QTR_CNT_W'(0);
  localparam logic [QTR_CNT_W-1:0]   QTR_1      = QTR_CNT_W'(1);
  localparam logic [QTR_CNT_W-1:0]   QTR_2      = QTR_CNT_W'(2);
  localparam logic [QTR_CNT_W-1:0]   QTR_3      = QTR_CNT_W'(3);
  localparam logic [TICK_CNT_W-1:0]  CNT_ZERO   = TICK_CNT_W'(0);
  localparam logic [TICK_CNT_W-1:0]  CNT_ONE    = TICK_CNT_W'(1);
  localparam logic [TICK_CNT_W-1:0]  CNT_TWO    = TICK_CNT_W'(2);
  localparam logic [TICK_CNT_W-1:0]  DELAY_LAST = TICK_CNT_W'(DELAY_TICKS - 1);
  localparam logic [TICK_CNT_W-1:0]  GAP_LAST   = TICK_CNT_W'(GAP_TICKS - 1);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [15:0]            entry_q, entry_d;
  logic [PHASE_CNT_W-1:0] phase_q, phase_d;
  logic [BIT_CNT_W-1:0]   bit_q, bit_d;
  logic [QTR_CNT_W-1:0]   qtr_q, qtr_d;
  logic [TICK_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   sioc_q, sioc_d;
  logic                   siod_q, siod_d;
  logic                   oe_q, oe_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [7:0]             cur_byte_s;
  logic                   cur_bit_s;
  logic                   is_ack_s;
  logic [IDX_W-1:0]       idx_next_s;
  logic                   last_entry_s;
  logic [TICK_CNT_W-1:0]  wait_last_s;

  // Select the byte being shifted out in the current phase.
  always_comb begin
    cur_byte_s = DEVICE_ADDR;
    case (phase_q)
      2'd0:    cur_byte_s = DEVICE_ADDR;
      2'd1:    cur_byte_s = entry_q[15:8];
      2'd2:    cur_byte_s = entry_q[7:0];
      default: cur_byte_s = DEVICE_ADDR;
    endcase
  end

  assign cur_bit_s    = cur_byte_s[3'd7 - bit_q[2:0]];
  assign is_ack_s     = (bit_q == ACK_BIT);
  assign idx_next_s   = idx_q + IDX_ONE;
  assign last_entry_s = (idx_next_s == IDX_END);
  assign wait_last_s  = (state_q == ST_DELAY) ? DELAY_LAST : GAP_LAST;

  // Next-state and next-output logic; evaluated for every enable tick.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    entry_d = entry_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    qtr_d   = qtr_q;
    cnt_d   = cnt_q;
    sioc_d  = sioc_q;
    siod_d  = siod_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      ST_IDLE: begin
        entry_d = table_entry(32'(idx_q));
        busy_d  = 1'b1;
        cnt_d   = CNT_ZERO;
        state_d = ST_START;
      end

      ST_START: begin
        // SIOD falls with SIOC high, then SIOC drops to open the first bit.
        oe_d = 1'b1;
        if (cnt_q == CNT_ZERO) begin
          siod_d = 1'b0;
          cnt_d  = CNT_ONE;
        end else begin
          sioc_d  = 1'b0;
          cnt_d   = CNT_ZERO;
          phase_d = PHASE_ZERO;
          bit_d   = BIT_ZERO;
          qtr_d   = QTR_0;
          state_d = ST_BIT;
        end
      end

      ST_BIT: begin
        case (qtr_q)
          QTR_0: begin
            sioc_d = 1'b0;
            qtr_d  = QTR_1;
          end
          QTR_1: begin
            // Data only changes here, while SIOC is low.
            if (is_ack_s) begin
              siod_d = 1'b1;
              oe_d   = 1'b0;
            end else begin
              siod_d = cur_bit_s;
              oe_d   = 1'b1;
            end
            qtr_d = QTR_2;
          end
          QTR_2: begin
            sioc_d = 1'b1;
            qtr_d  = QTR_3;
          end
          default: begin
            sioc_d = 1'b1;
            qtr_d  = QTR_0;
            if (is_ack_s) begin
              bit_d = BIT_ZERO;
              if (phase_q == PHASE_LAST) begin
                phase_d = PHASE_ZERO;
                cnt_d   = CNT_ZERO;
                state_d = ST_STOP;
              end else begin
                phase_d = phase_q + PHASE_ONE;
              end
            end else begin
              bit_d = bit_q + BIT_ONE;
            end
          end
        endcase
      end

      ST_STOP: begin
        if (cnt_q == CNT_ZERO) begin
          sioc_d = 1'b0;
          siod_d = 1'b0;
          oe_d   = 1'b1;
          cnt_d  = CNT_ONE;
        end else if (cnt_q == CNT_ONE) begin
          sioc_d = 1'b1;
          cnt_d  = CNT_TWO;
        end else begin
          // SIOD rises with SIOC high: stop condition.
          siod_d = 1'b1;
          cnt_d  = CNT_ZERO;
          state_d = (idx_q == IDX_ZERO) ? ST_DELAY : ST_GAP;
        end
      end

      ST_GAP, ST_DELAY: begin
        // Idle bus; the soft-reset entry gets the long settling delay.
        if (cnt_q == wait_last_s) begin
          cnt_d = CNT_ZERO;
          idx_d = idx_next_s;
          if (last_entry_s) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            entry_d = table_entry(32'(idx_next_s));
            state_d = ST_START;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DONE: begin
        sioc_d = 1'b1;
        siod_d = 1'b1;
        oe_d   = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        sioc_d  = 1'b1;
        siod_d  = 1'b1;
        oe_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers: reset wins, otherwise advance only on ticks.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_ZERO;
      entry_q <= 16'h0000;
      phase_q <= PHASE_ZERO;
      bit_q   <= BIT_ZERO;
      qtr_q   <= QTR_0;
      cnt_q   <= CNT_ZERO;
      sioc_q  <= 1'b1;
      siod_q  <= 1'b1;
      oe_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (i_enable) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      entry_q <= entry_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      qtr_q   <= qtr_d;
      cnt_q   <= cnt_d;
      sioc_q  <= sioc_d;
      siod_q  <= siod_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_sioc    = sioc_q;
  assign o_siod    = siod_q;
  assign o_siod_oe = oe_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_cam_default_reg_writer.sv
// Directed bench for cam_default_reg_writer: decodes the SCCB bus, checks
// reset behaviour, bit order, tick timing, sequencing, freeze and restart.
module tb_cam_default_reg_writer;

  localparam int DELAY_T = 10;
  localparam int GAP_T   = 8;

  logic clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_enable;
  logic o_sioc, o_siod, o_siod_oe, o_busy, o_done;

  int vectors = 0;
  int miscompares = 0;

  // Enable generator: 0 = off, 1 = every clk, 2 = one clk in four.
  int en_mode = 1;
  logic [1:0] div = 2'd0;
  int cyc = 0;

  cam_default_reg_writer #(
    .DEVICE_ADDR(8'h42),
    .NUM_REGS(8),
    .DELAY_TICKS(DELAY_T),
    .GAP_TICKS(GAP_T)
  ) dut (
    .clk(clk),
    .i_reset(i_reset),
    .i_enable(i_enable),
    .o_sioc(o_sioc),
    .o_siod(o_siod),
    .o_siod_oe(o_siod_oe),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    div <= div + 2'd1;
  end

  assign i_enable = (en_mode == 1) ? 1'b1 : ((en_mode == 2) ? (div == 2'd0) : 1'b0);

  // Expected transactions {dev, reg, val}, in table order.
  logic [23:0] exp_x [8] = '{24'h421280, 24'h421204, 24'h421101, 24'h420C00,
                             24'h423E00, 24'h4240D0, 24'h428C00, 24'h423A04};

  // Bus monitor state.
  logic        p_sioc = 1'b1, p_siod = 1'b1;
  bit          in_xfer = 1'b0;
  int          nbits = 0;
  logic [23:0] shreg = 24'h0;
  logic [23:0] xfer_q [$];
  int          start_q [$];
  int          stop_q [$];
  int          mon_err = 0;
  bit          have_rise = 1'b0;
  int          rise_last = 0, per_min = 0, per_max = 0, last_per_min = 0, last_per_max = 0;

  // Decode starts, bits and stops; flag any SIOD change with SIOC high that
  // is not a well-placed START or STOP, and any wrong drive on ACK slots.
  initial begin
    forever begin
      @(negedge clk);
      if (i_reset) begin
        in_xfer = 1'b0;
        nbits = 0;
      end else if (p_sioc && o_sioc && p_siod && !o_siod) begin
        if (in_xfer) mon_err++;
        in_xfer = 1'b1;
        nbits = 0;
        shreg = 24'h0;
        have_rise = 1'b0;
        per_min = 1 << 30;
        per_max = 0;
        start_q.push_back(cyc);
      end else if (p_sioc && o_sioc && !p_siod && o_siod) begin
        if (!in_xfer || nbits != 27) begin
          mon_err++;
        end else begin
          xfer_q.push_back(shreg);
          last_per_min = per_min;
          last_per_max = per_max;
        end
        stop_q.push_back(cyc);
        in_xfer = 1'b0;
      end else if (!p_sioc && o_sioc && in_xfer && nbits < 27) begin
        if (nbits % 9 == 8) begin
          if (o_siod_oe !== 1'b0 || o_siod !== 1'b1) mon_err++;
        end else begin
          if (o_siod_oe !== 1'b1) mon_err++;
          shreg = {shreg[22:0], o_siod};
        end
        if (have_rise) begin
          if (cyc - rise_last < per_min) per_min = cyc - rise_last;
          if (cyc - rise_last > per_max) per_max = cyc - rise_last;
        end
        have_rise = 1'b1;
        rise_last = cyc;
        nbits++;
      end
      p_sioc = o_sioc;
      p_siod = o_siod;
    end
  end

  task automatic do_reset(input int n);
    i_reset = 1'b1;
    repeat (n) @(negedge clk);
    xfer_q.delete();
    start_q.delete();
    stop_q.delete();
    i_reset = 1'b0;
  endtask

  task automatic wait_xfers(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (xfer_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reset values, then the first ten ticks sample-by-sample and the first write.
  task automatic test_reset();
    logic [4:0] exp_s [10] = '{5'b11110, 5'b10110, 5'b00110, 5'b00110, 5'b00110,
                               5'b10110, 5'b10110, 5'b00110, 5'b01110, 5'b11110};
    bit ok;
    en_mode = 1;
    i_reset = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if ({o_sioc, o_siod, o_siod_oe, o_busy, o_done} !== 5'b11100) begin
      miscompares++;
      $display("FAIL reset_values: got %b expected %b", {o_sioc, o_siod, o_siod_oe, o_busy, o_done}, 5'b11100);
    end
    xfer_q.delete();
    start_q.delete();
    stop_q.delete();
    i_reset = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      vectors++;
      if ({o_sioc, o_siod, o_siod_oe, o_busy, o_done} !== exp_s[t]) begin
        miscompares++;
        $display("FAIL first_ticks[%0d]: got %b expected %b", t, {o_sioc, o_siod, o_siod_oe, o_busy, o_done}, exp_s[t]);
      end
    end
    wait_xfers(1, 200, ok);
    vectors++;
    if (!ok || xfer_q[0] !== 24'h421280) begin
      miscompares++;
      $display("FAIL first_write: got %h (seen=%0d) expected %h", ok ? xfer_q[0] : 24'h0, ok, 24'h421280);
    end
  endtask

  // One tick every 4 clks: SIOC period 16 clks, START-to-STOP edge 112 ticks.
  task automatic test_tick_period();
    bit ok;
    en_mode = 2;
    do_reset(4);
    wait_xfers(1, 700, ok);
    vectors++;
    if (!ok || xfer_q[0] !== 24'h421280) begin
      miscompares++;
      $display("FAIL div4_write: got %h (seen=%0d) expected %h", ok ? xfer_q[0] : 24'h0, ok, 24'h421280);
    end
    vectors++;
    if (!ok || (stop_q[0] - start_q[0]) != 448) begin
      miscompares++;
      $display("FAIL div4_span: got %0d clks expected %0d", ok ? stop_q[0] - start_q[0] : -1, 448);
    end
    vectors++;
    if (last_per_min != 16 || last_per_max != 16) begin
      miscompares++;
      $display("FAIL div4_sioc_period: got min %0d max %0d expected 16", last_per_min, last_per_max);
    end
  endtask

  // Whole table, inter-transaction spacing, done/busy handover, sticky done.
  task automatic test_full_run();
    bit found = 1'b0;
    logic prev_busy = 1'b0;
    int done_cyc = 0;
    int exp_gap;
    en_mode = 1;
    do_reset(3);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (o_done === 1'b1) begin
        found = 1'b1;
        done_cyc = cyc;
        break;
      end
      prev_busy = o_busy;
    end
    vectors++;
    if (!found || o_busy !== 1'b0 || prev_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL done_handover: done_seen=%0d busy=%b busy_before=%b expected 1/0/1", found, o_busy, prev_busy);
    end
    vectors++;
    if (xfer_q.size() != 8) begin
      miscompares++;
      $display("FAIL write_count: got %0d expected %0d", xfer_q.size(), 8);
    end
    for (int k = 0; k < 8 && k < xfer_q.size(); k++) begin
      vectors++;
      if (xfer_q[k] !== exp_x[k]) begin
        miscompares++;
        $display("FAIL table_write[%0d]: got %h expected %h", k, xfer_q[k], exp_x[k]);
      end
    end
    for (int k = 0; k < 7 && k + 1 < start_q.size() && k < stop_q.size(); k++) begin
      exp_gap = (k == 0) ? DELAY_T + 1 : GAP_T + 1;
      vectors++;
      if (start_q[k+1] - stop_q[k] != exp_gap) begin
        miscompares++;
        $display("FAIL spacing[%0d]: got %0d clks expected %0d", k, start_q[k+1] - stop_q[k], exp_gap);
      end
    end
    vectors++;
    if (stop_q.size() != 8 || done_cyc - stop_q[stop_q.size()-1] != GAP_T) begin
      miscompares++;
      $display("FAIL done_after_gap: got %0d clks expected %0d", stop_q.size() > 0 ? done_cyc - stop_q[stop_q.size()-1] : -1, GAP_T);
    end
    repeat (50) @(negedge clk);
    vectors++;
    if ({o_sioc, o_siod, o_siod_oe, o_busy, o_done} !== 5'b11101 || xfer_q.size() != 8) begin
      miscompares++;
      $display("FAIL done_sticky: got %b writes=%0d expected %b writes=8", {o_sioc, o_siod, o_siod_oe, o_busy, o_done}, xfer_q.size(), 5'b11101);
    end
  endtask

  // Reset in the middle of entry 3 aborts at once and restarts from entry 0.
  task automatic test_reset_mid();
    bit ok = 1'b0;
    en_mode = 1;
    do_reset(3);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (start_q.size() >= 4) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL reach_entry3: got %0d starts expected 4", start_q.size());
    end
    repeat (40) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({o_sioc, o_siod, o_siod_oe, o_busy, o_done} !== 5'b11100) begin
      miscompares++;
      $display("FAIL mid_reset_values: got %b expected %b", {o_sioc, o_siod, o_siod_oe, o_busy, o_done}, 5'b11100);
    end
    do_reset(19);
    wait_xfers(1, 200, ok);
    vectors++;
    if (!ok || xfer_q[0] !== 24'h421280) begin
      miscompares++;
      $display("FAIL restart_entry0: got %h (seen=%0d) expected %h", ok ? xfer_q[0] : 24'h0, ok, 24'h421280);
    end
  endtask

  // Enable dropped for 50 clks mid-bit: outputs frozen, bit stream intact.
  task automatic test_enable_freeze();
    bit ok = 1'b0;
    bit frozen = 1'b1;
    logic [4:0] snap;
    en_mode = 1;
    do_reset(3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (start_q.size() >= 1) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (31) @(negedge clk);
    en_mode = 0;
    snap = {o_sioc, o_siod, o_siod_oe, o_busy, o_done};
    repeat (50) begin
      @(negedge clk);
      if ({o_sioc, o_siod, o_siod_oe, o_busy, o_done} !== snap) frozen = 1'b0;
    end
    en_mode = 1;
    vectors++;
    if (!frozen) begin
      miscompares++;
      $display("FAIL freeze_hold: got %b expected held %b", {o_sioc, o_siod, o_siod_oe, o_busy, o_done}, snap);
    end
    wait_xfers(1, 300, ok);
    vectors++;
    if (!ok || xfer_q[0] !== 24'h421280) begin
      miscompares++;
      $display("FAIL freeze_write: got %h (seen=%0d) expected %h", ok ? xfer_q[0] : 24'h0, ok, 24'h421280);
    end
    vectors++;
    if (!ok || stop_q[0] - start_q[0] != 162) begin
      miscompares++;
      $display("FAIL freeze_span: got %0d clks expected %0d", ok ? stop_q[0] - start_q[0] : -1, 162);
    end
  endtask

  // Bus legality accumulated over every test above.
  task automatic test_protocol();
    vectors++;
    if (mon_err != 0) begin
      miscompares++;
      $display("FAIL bus_protocol: got %0d violations expected 0", mon_err);
    end
  endtask

  initial begin
    test_reset();
    test_tick_period();
    test_full_run();
    test_reset_mid();
    test_enable_freeze();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
